ibex_register_file_init: RTL and testbench

IBEX_REGISTER_FILE_INIT -- requirements
Module: ibex_register_file_init

---
 rtl/ibex_register_file_init.sv | 132 +++++++++++++
 tb/tb_ibex_register_file_init.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_register_file_init.sv
// Register file initialisation engine: fills words 1..N-1 with a fixed value,
// optionally reads them back, then hands the register file ports to the core.
module ibex_register_file_init #(
    parameter bit                   RV32E         = 1'b0,
    parameter int unsigned          DataWidth     = 32,
    parameter logic [DataWidth-1:0] WordZeroVal   = '0,
    parameter bit                   ReadbackCheck = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,

    input  logic [4:0]           core_waddr_i,
    input  logic [DataWidth-1:0] core_wdata_i,
    input  logic                 core_we_i,
    input  logic [4:0]           core_raddr_a_i,

    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    output logic                 rf_we_o,
    output logic [4:0]           rf_raddr_a_o,
    input  logic [DataWidth-1:0] rf_rdata_a_i,

    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);

    localparam int unsigned     NUM_WORDS = RV32E ? 16 : 32;
    localparam int unsigned     CNT_W     = 5;
    localparam logic [CNT_W-1:0] FIRST_ADDR = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_ADDR  = CNT_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        FILL  = 2'd1,
        CHECK = 2'd2,
        IDLE  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    // State, address counter and sticky status flags
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= INIT;
            cnt_q   <= FIRST_ADDR;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next state and port muxing; the core path is the default routing
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        done_d       = done_q;
        err_d        = err_q;
        rf_waddr_o   = core_waddr_i;
        rf_wdata_o   = core_wdata_i;
        rf_we_o      = 1'b0;
        rf_raddr_a_o = core_raddr_a_i;
        busy_o       = 1'b1;

        // A core write while the engine owns the ports is dropped and flagged
        if ((state_q != IDLE) && core_we_i) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            INIT: begin
                state_d = FILL;
                cnt_d   = FIRST_ADDR;
            end
            FILL: begin
                rf_we_o    = 1'b1;
                rf_waddr_o = cnt_q;
                rf_wdata_o = WordZeroVal;
                if (cnt_q == LAST_ADDR) begin
                    cnt_d = FIRST_ADDR;
                    if (ReadbackCheck) begin
                        state_d = CHECK;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CHECK: begin
                rf_raddr_a_o = cnt_q;
                if (rf_rdata_a_i != WordZeroVal) begin
                    err_d = 1'b1;
                end
                if (cnt_q == LAST_ADDR) begin
                    cnt_d   = FIRST_ADDR;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            IDLE: begin
                busy_o  = 1'b0;
                rf_we_o = core_we_i;
                if (start_i) begin
                    state_d = INIT;
                    cnt_d   = FIRST_ADDR;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = INIT;
                cnt_d   = FIRST_ADDR;
            end
        endcase
    end

    assign done_o = done_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_ibex_register_file_init.sv
// Directed bench for ibex_register_file_init: a 32-word instance with readback
// and a 16-word instance without, driven on negedge and sampled 1 time unit later.
module tb_ibex_register_file_init;

    localparam logic [31:0] FILL_VAL = 32'hDEADBEEF;

    logic        clk;
    logic        rst_n, rst2_n;
    logic        start;
    logic [4:0]  core_waddr;
    logic [31:0] core_wdata;
    logic        core_we;
    logic [4:0]  core_raddr;
    logic        corrupt;

    logic [4:0]  waddr1, raddr1;
    logic [31:0] wdata1, rdata1;
    logic        we1, busy1, done1, err1;

    logic [4:0]  waddr2, raddr2;
    logic [31:0] wdata2;
    logic        we2, busy2, done2, err2;
    logic        start2;

    logic [31:0] mem [32];

    int nchk = 0;
    int nerr = 0;

    ibex_register_file_init #(
        .RV32E(1'b0), .DataWidth(32), .WordZeroVal(FILL_VAL), .ReadbackCheck(1'b1)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start),
        .core_waddr_i(core_waddr), .core_wdata_i(core_wdata), .core_we_i(core_we),
        .core_raddr_a_i(core_raddr),
        .rf_waddr_o(waddr1), .rf_wdata_o(wdata1), .rf_we_o(we1), .rf_raddr_a_o(raddr1),
        .rf_rdata_a_i(rdata1),
        .busy_o(busy1), .done_o(done1), .err_o(err1)
    );

    ibex_register_file_init #(
        .RV32E(1'b1), .DataWidth(32), .WordZeroVal(32'h0), .ReadbackCheck(1'b0)
    ) dut2 (
        .clk_i(clk), .rst_ni(rst2_n), .start_i(start2),
        .core_waddr_i(core_waddr), .core_wdata_i(core_wdata), .core_we_i(core_we),
        .core_raddr_a_i(core_raddr),
        .rf_waddr_o(waddr2), .rf_wdata_o(wdata2), .rf_we_o(we2), .rf_raddr_a_o(raddr2),
        .rf_rdata_a_i(32'h0),
        .busy_o(busy2), .done_o(done2), .err_o(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model behind the 32-word instance, with optional read fault at word 7
    always @(posedge clk) begin
        if (we1) mem[waddr1] <= wdata1;
    end
    assign rdata1 = (corrupt && raddr1 == 5'd7) ? 32'h0 : mem[raddr1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_fill(input int upto);
        for (int k = 1; k <= upto; k++) begin
            @(negedge clk); #1;
            chk($sformatf("fill_we[%0d]", k), 32'(we1), 32'd1);
            chk($sformatf("fill_waddr[%0d]", k), 32'(waddr1), k);
            chk($sformatf("fill_wdata[%0d]", k), wdata1, FILL_VAL);
            chk($sformatf("fill_busy[%0d]", k), 32'(busy1), 32'd1);
        end
    endtask

    task automatic run_check(input logic base_err, input bit inj);
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk); #1;
            chk($sformatf("chk_we[%0d]", k), 32'(we1), 32'd0);
            chk($sformatf("chk_raddr[%0d]", k), 32'(raddr1), k);
            chk($sformatf("chk_busy[%0d]", k), 32'(busy1), 32'd1);
            chk($sformatf("chk_err[%0d]", k), 32'(err1), 32'(base_err | (inj && k >= 8)));
        end
    endtask

    task automatic end_idle(input string tag, input logic exp_err);
        @(negedge clk); #1;
        chk({tag, "_busy"}, 32'(busy1), 32'd0);
        chk({tag, "_done"}, 32'(done1), 32'd1);
        chk({tag, "_err"},  32'(err1), 32'(exp_err));
    endtask

    task automatic start_pass(input string tag);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk({tag, "_init_busy"}, 32'(busy1), 32'd1);
        chk({tag, "_init_we"},   32'(we1), 32'd0);
        chk({tag, "_init_done"}, 32'(done1), 32'd0);
        chk({tag, "_init_err"},  32'(err1), 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  raddr;
        logic        exp_we;
        logic [4:0]  exp_waddr;
        logic [31:0] exp_wdata;
        logic [4:0]  exp_raddr;
    } vec_t;

    vec_t vecs [4];

    initial begin
        vecs[0] = '{1'b1, 5'd5,  32'h12345678, 5'd3,  1'b1, 5'd5,  32'h12345678, 5'd3};
        vecs[1] = '{1'b0, 5'd17, 32'hA5A5A5A5, 5'd31, 1'b0, 5'd17, 32'hA5A5A5A5, 5'd31};
        vecs[2] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd0,  1'b1, 5'd31, 32'hFFFFFFFF, 5'd0};
        vecs[3] = '{1'b1, 5'd1,  32'h00000001, 5'd16, 1'b1, 5'd1,  32'h00000001, 5'd16};

        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        rst_n = 1'b0; rst2_n = 1'b0; start = 1'b0; start2 = 1'b0; corrupt = 1'b0;
        core_we = 1'b0; core_waddr = 5'd0; core_wdata = 32'h0; core_raddr = 5'd0;

        // Reset state, then full power-on sequence
        @(negedge clk); @(negedge clk); #1;
        chk("rst_busy", 32'(busy1), 32'd1);
        chk("rst_we",   32'(we1), 32'd0);
        chk("rst_done", 32'(done1), 32'd0);
        chk("rst_err",  32'(err1), 32'd0);
        rst_n = 1'b1; #1;
        chk("init_we",   32'(we1), 32'd0);
        chk("init_busy", 32'(busy1), 32'd1);
        run_fill(31);
        run_check(1'b0, 1'b0);
        end_idle("pwr", 1'b0);
        chk("word0_untouched", mem[0], 32'h0);
        chk("word31_filled", mem[31], FILL_VAL);

        // Core pass-through in IDLE
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            core_we = vecs[i].we; core_waddr = vecs[i].waddr;
            core_wdata = vecs[i].wdata; core_raddr = vecs[i].raddr;
            #1;
            chk($sformatf("pt_we[%0d]", i),    32'(we1), 32'(vecs[i].exp_we));
            chk($sformatf("pt_waddr[%0d]", i), 32'(waddr1), 32'(vecs[i].exp_waddr));
            chk($sformatf("pt_wdata[%0d]", i), wdata1, vecs[i].exp_wdata);
            chk($sformatf("pt_raddr[%0d]", i), 32'(raddr1), 32'(vecs[i].exp_raddr));
            chk($sformatf("pt_busy[%0d]", i),  32'(busy1), 32'd0);
        end

        // start and core write together, then core write and stray start mid-fill
        @(negedge clk);
        core_we = 1'b1; core_waddr = 5'd9; core_wdata = 32'hCAFE0001; core_raddr = 5'd0;
        start = 1'b1; #1;
        chk("both_we",    32'(we1), 32'd1);
        chk("both_waddr", 32'(waddr1), 32'd9);
        chk("both_wdata", wdata1, 32'hCAFE0001);
        @(negedge clk);
        start = 1'b0; core_we = 1'b0; #1;
        chk("both_init_busy", 32'(busy1), 32'd1);
        chk("both_init_done", 32'(done1), 32'd0);
        chk("both_init_we",   32'(we1), 32'd0);
        for (int k = 1; k <= 31; k++) begin
            @(negedge clk);
            core_we = (k == 10); core_waddr = 5'd3; core_wdata = 32'h00000055;
            start = (k == 15);
            #1;
            chk($sformatf("cw_waddr[%0d]", k), 32'(waddr1), k);
            chk($sformatf("cw_wdata[%0d]", k), wdata1, FILL_VAL);
            chk($sformatf("cw_we[%0d]", k), 32'(we1), 32'd1);
            chk($sformatf("cw_err[%0d]", k), 32'(err1), 32'(k > 10));
        end
        core_we = 1'b0; start = 1'b0;
        run_check(1'b1, 1'b0);
        end_idle("cw", 1'b1);

        // Readback mismatch at word 7
        corrupt = 1'b1;
        @(negedge clk);
        start_pass("rb");
        run_fill(31);
        run_check(1'b0, 1'b1);
        end_idle("rb", 1'b1);
        corrupt = 1'b0;

        // Reset mid-fill restarts from word 1
        @(negedge clk);
        start_pass("mr");
        run_fill(20);
        rst_n = 1'b0; #1;
        chk("mr_rst_we",   32'(we1), 32'd0);
        chk("mr_rst_busy", 32'(busy1), 32'd1);
        chk("mr_rst_done", 32'(done1), 32'd0);
        @(negedge clk); #1;
        chk("mr_rst_we2", 32'(we1), 32'd0);
        rst_n = 1'b1; #1;
        chk("mr_init_we", 32'(we1), 32'd0);
        run_fill(31);
        run_check(1'b0, 1'b0);
        end_idle("mr", 1'b0);

        // 16-word instance without readback: 16 cycles to IDLE
        @(negedge clk); #1;
        chk("e_rst_busy", 32'(busy2), 32'd1);
        chk("e_rst_we",   32'(we2), 32'd0);
        chk("e_rst_done", 32'(done2), 32'd0);
        rst2_n = 1'b1; #1;
        chk("e_init_we", 32'(we2), 32'd0);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk); #1;
            chk($sformatf("e_we[%0d]", k),    32'(we2), 32'd1);
            chk($sformatf("e_waddr[%0d]", k), 32'(waddr2), k);
            chk($sformatf("e_wdata[%0d]", k), wdata2, 32'h0);
            chk($sformatf("e_done[%0d]", k),  32'(done2), 32'd0);
        end
        @(negedge clk); #1;
        chk("e_idle_busy", 32'(busy2), 32'd0);
        chk("e_idle_done", 32'(done2), 32'd1);
        chk("e_idle_err",  32'(err2), 32'd0);
        chk("e_idle_we",   32'(we2), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
